// File: rtl/spi_regfile_pkg.sv
// Shared types and frame-size helpers for the SPI register-file peripheral.
package spi_regfile_pkg;

    // Frame tracking states of the peripheral.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CMD      = 2'd1,
        DATA     = 2'd2,
        WAIT_END = 2'd3
    } state_e;

    // Bits in a complete frame: R/W flag, address field, data field.
    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    // Bit counter width; it must hold FRAME_LEN+1 so an overrun is visible.
    function automatic int cnt_width(input int addr_w, input int data_w);
        return $clog2(frame_len(addr_w, data_w) + 2);
    endfunction

    localparam int FRAME_LEN = frame_len(7, 8);
    localparam int CNT_W     = cnt_width(7, 8);

endpackage

// File: rtl/spi_regfile_peripheral_if.sv
// Pin and status bundle of the SPI register-file peripheral.
// Handshake: there is no valid/ready pair. A transfer is framed by ncs
// (active low). The controller changes copi while sclk is low, and the
// peripheral samples it on each sclk rising edge. The peripheral changes
// cipo after each sclk falling edge. wr_strobe and frame_err are one-clk
// pulses on the system clock, and the consumer must not stall them.
interface spi_regfile_peripheral_if #(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8
);
    logic                       sclk;
    logic                       ncs;
    logic                       copi;
    logic                       cipo;
    logic                       cipo_oe;
    logic [NUM_REGS*DATA_W-1:0] reg_q;
    logic [NUM_REGS-1:0]        wr_strobe;
    logic                       frame_err;

    modport master (
        output sclk, ncs, copi,
        input  cipo, cipo_oe, reg_q, wr_strobe, frame_err
    );

    modport slave (
        input  sclk, ncs, copi,
        output cipo, cipo_oe, reg_q, wr_strobe, frame_err
    );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with a prev flop for edge detection on an async input.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the async input through the chain and remember the last settled level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;
endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 register file: framed writes with per-register strobes, read-back on CIPO.
module spi_regfile_peripheral
    import spi_regfile_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic   clk,
    input  logic   rst,
    spi_regfile_peripheral_if.slave bus,
    output state_e dbg_state_o
);
    localparam int FLEN = frame_len(ADDR_W, DATA_W);
    localparam int CW   = cnt_width(ADDR_W, DATA_W);
    localparam int SW   = $clog2(SYNC_STAGES + 1);
    localparam int RW   = NUM_REGS * DATA_W;

    logic sclk_rise, sclk_fall, unused_sclk_lvl;
    logic ncs_lvl, ncs_rise, ncs_fall;
    logic copi_lvl, unused_copi_rise, unused_copi_fall;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ADDR_W:0]     cmd_q, cmd_d, cmd_next;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rd_q, rd_d, pend_data_q, pend_data_d;
    logic [DATA_W-1:0]   rd_lookup;
    logic [DATA_W:0]     wd_ext, rd_ext;
    logic                oe_q, oe_d, pend_q, pend_d, err_q, err_d;
    logic [RW-1:0]       regs_q, regs_d;
    logic [NUM_REGS-1:0] strobe_q, strobe_d;
    logic [SW-1:0]       settle_q, settle_d;
    logic                armed_q, armed_d, settled, addr_ok;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(bus.sclk),
        .level_o(unused_sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .d_i(bus.ncs),
        .level_o(ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .d_i(bus.copi),
        .level_o(copi_lvl), .rise_o(unused_copi_rise), .fall_o(unused_copi_fall)
    );

    // The ncs chain resets high; if the pin is low when reset releases, the chain
    // would fake a falling edge. Only accept a frame start once a real high ncs
    // has been seen after the chain has filled with real samples.
    assign settled  = (settle_q == SW'(SYNC_STAGES));
    assign addr_ok  = (32'(addr_q) < NUM_REGS);
    assign cmd_next = {cmd_q[ADDR_W-1:0], copi_lvl};
    assign wd_ext   = {wdata_q, copi_lvl};
    assign rd_ext   = {rd_q, 1'b0};

    // Read-back value for the address being latched; unimplemented addresses read 0
    always_comb begin
        rd_lookup = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_next[ADDR_W-1:0] == ADDR_W'(i)) rd_lookup = regs_q[i*DATA_W +: DATA_W];
        end
    end

    // Frame tracking: ncs rising has priority over any coincident sclk edge
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        oe_d        = oe_q;
        pend_d      = 1'b0;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        err_d       = 1'b0;
        settle_d    = settled ? settle_q : settle_q + SW'(1);
        armed_d     = armed_q | (settled & ncs_lvl);
        if (ncs_rise) begin
            if (state_q != IDLE) begin
                if (cnt_q == CW'(FLEN)) begin
                    pend_d      = rw_q & addr_ok;
                    pend_addr_d = addr_q;
                    pend_data_d = wdata_q;
                end else begin
                    err_d = 1'b1;
                end
            end
            state_d = IDLE;
            oe_d    = 1'b0;
        end else if (state_q == IDLE) begin
            if (ncs_fall && armed_q) begin
                state_d = CMD;
                cnt_d   = '0;
                cmd_d   = '0;
                wdata_d = '0;
                rd_d    = '0;
                oe_d    = 1'b1;
            end
        end else if (sclk_rise && !ncs_lvl) begin
            if (cnt_q != CW'(FLEN + 1)) cnt_d = cnt_q + CW'(1);
            case (state_q)
                CMD: begin
                    cmd_d = cmd_next;
                    if (cnt_q == CW'(ADDR_W)) begin
                        rw_d    = cmd_next[ADDR_W];
                        addr_d  = cmd_next[ADDR_W-1:0];
                        rd_d    = cmd_next[ADDR_W] ? '0 : rd_lookup;
                        state_d = DATA;
                    end
                end
                DATA: begin
                    wdata_d = wd_ext[DATA_W-1:0];
                    if (cnt_q == CW'(FLEN - 1)) state_d = WAIT_END;
                end
                default: ;
            endcase
        end else if (sclk_fall && !ncs_lvl && state_q == DATA && cnt_q != CW'(ADDR_W + 1)) begin
            // The falling edge right after the command latch must not shift:
            // the first data bit is already on cipo.
            rd_d = rd_ext[DATA_W-1:0];
        end
    end

    // Commit stage: write the register and pulse its strobe one clk after acceptance
    always_comb begin
        strobe_d = '0;
        regs_d   = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (pend_q && pend_addr_q == ADDR_W'(i)) begin
                strobe_d[i]                = 1'b1;
                regs_d[i*DATA_W +: DATA_W] = pend_data_q;
            end
        end
    end

    // State, datapath and register-file flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            oe_q        <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            err_q       <= 1'b0;
            regs_q      <= '0;
            strobe_q    <= '0;
            settle_q    <= '0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            oe_q        <= oe_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            err_q       <= err_d;
            regs_q      <= regs_d;
            strobe_q    <= strobe_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
        end
    end

    assign bus.cipo      = (state_q == DATA) && !rw_q && rd_q[DATA_W-1];
    assign bus.cipo_oe   = oe_q;
    assign bus.reg_q     = regs_q;
    assign bus.wr_strobe = strobe_q;
    assign bus.frame_err = err_q;
    assign dbg_state_o   = state_q;
endmodule
